// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared types and helpers for the keypad entry controller.
package keypad_entry_ctrl_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    SUBMIT  = 3'd2,
    WAIT    = 3'd3,
    UNLOCK  = 3'd4,
    LOCKED  = 3'd5
  } state_t;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad-side and checker-side signals of the entry controller.
interface keypad_entry_ctrl_if
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DIGITS = 3
) ();

  localparam int PW = DIGIT_W * DIGITS;
  localparam int CW = clog2w(DIGITS + 1);

  logic               key_valid;
  logic [DIGIT_W-1:0] key_code;
  logic               key_clear;
  logic               key_submit;
  logic               access;
  logic               alarm;
  logic [PW-1:0]      pass_word;
  logic               enter;
  logic [CW-1:0]      digit_cnt;
  logic               busy;
  logic               unlocked;
  logic               locked_out;
  logic               bad_entry;
  logic               fail;

  modport slave (
    input  key_valid, key_code, key_clear, key_submit, access, alarm,
    output pass_word, enter, digit_cnt, busy, unlocked, locked_out, bad_entry, fail
  );

  modport master (
    output key_valid, key_code, key_clear, key_submit, access, alarm,
    input  pass_word, enter, digit_cnt, busy, unlocked, locked_out, bad_entry, fail
  );

endinterface

// File: rtl/keypad_entry_ctrl_down_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module keypad_entry_ctrl_down_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad front end: assembles hex digits into a password, strobes it into
// the checker, then acts on the access/alarm verdict.
//
//   state   | meaning
//   IDLE    | empty buffer, waiting for a first key
//   COLLECT | partial/full entry held, idle timeout running
//   SUBMIT  | enter strobe high, pass_word frozen
//   WAIT    | checker response delay, verdict sampled at terminal count
//   UNLOCK  | door-release window, keys ignored
//   LOCKED  | lockout latched until reset
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DIGITS        = 3,
  parameter int ENTER_W       = 2,
  parameter int RESP_WAIT     = 2,
  parameter int TIMEOUT       = 1000,
  parameter int UNLOCK_CYCLES = 500
) (
  input logic                 clk,
  input logic                 rstn,
  keypad_entry_ctrl_if.slave  bus
);

  localparam int PW   = DIGIT_W * DIGITS;
  localparam int CW   = clog2w(DIGITS + 1);
  localparam int TM_A = (TIMEOUT > UNLOCK_CYCLES) ? TIMEOUT : UNLOCK_CYCLES;
  localparam int TM_B = (ENTER_W > RESP_WAIT) ? ENTER_W : RESP_WAIT;
  localparam int TMAX = (TM_A > TM_B) ? TM_A : TM_B;
  localparam int TW   = clog2w(TMAX + 1);

  localparam logic [CW-1:0] CNT_FULL   = CW'(DIGITS);
  localparam logic [TW-1:0] LD_TIMEOUT = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] LD_ENTER   = TW'(ENTER_W - 1);
  localparam logic [TW-1:0] LD_RESP    = TW'(RESP_WAIT);
  localparam logic [TW-1:0] LD_UNLOCK  = TW'(UNLOCK_CYCLES - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] pw_q, pw_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          enter_q, enter_nxt;
  logic          busy_q, busy_nxt;
  logic          unl_q, unl_nxt;
  logic          lock_q, lock_nxt;
  logic          bad_q, bad_nxt;
  logic          fail_q, fail_nxt;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  keypad_entry_ctrl_down_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      pw_q    <= '0;
      cnt_q   <= '0;
      enter_q <= 1'b0;
      busy_q  <= 1'b0;
      unl_q   <= 1'b0;
      lock_q  <= 1'b0;
      bad_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pw_q    <= pw_nxt;
      cnt_q   <= cnt_nxt;
      enter_q <= enter_nxt;
      busy_q  <= busy_nxt;
      unl_q   <= unl_nxt;
      lock_q  <= lock_nxt;
      bad_q   <= bad_nxt;
      fail_q  <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pw_nxt    = pw_q;
    cnt_nxt   = cnt_q;
    enter_nxt = 1'b0;
    unl_nxt   = 1'b0;
    lock_nxt  = 1'b0;
    bad_nxt   = 1'b0;
    fail_nxt  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    // An alarm from the checker overrides everything short of reset.
    if (state != LOCKED && bus.alarm) begin
      state_nxt = LOCKED;
      pw_nxt    = '0;
      cnt_nxt   = '0;
      lock_nxt  = 1'b1;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (bus.key_clear) begin
            state_nxt = IDLE;
            pw_nxt    = '0;
            cnt_nxt   = '0;
          end else if (bus.key_submit) begin
            if (cnt_q == CNT_FULL) begin
              state_nxt = SUBMIT;
              enter_nxt = 1'b1;
              tmr_load  = 1'b1;
              tmr_val   = LD_ENTER;
            end else begin
              state_nxt = IDLE;
              bad_nxt   = 1'b1;
              pw_nxt    = '0;
              cnt_nxt   = '0;
            end
          end else if (bus.key_valid && cnt_q != CNT_FULL) begin
            state_nxt = COLLECT;
            pw_nxt    = {pw_q[PW-DIGIT_W-1:0], bus.key_code};
            cnt_nxt   = cnt_q + CW'(1);
            tmr_load  = 1'b1;
            tmr_val   = LD_TIMEOUT;
          end else if (state == COLLECT && tmr_done) begin
            state_nxt = IDLE;
            pw_nxt    = '0;
            cnt_nxt   = '0;
          end
        end
        SUBMIT: begin
          if (tmr_done) begin
            state_nxt = WAIT;
            tmr_load  = 1'b1;
            tmr_val   = LD_RESP;
          end else begin
            enter_nxt = 1'b1;
          end
        end
        WAIT: begin
          if (tmr_done) begin
            pw_nxt  = '0;
            cnt_nxt = '0;
            if (bus.access) begin
              state_nxt = UNLOCK;
              unl_nxt   = 1'b1;
              tmr_load  = 1'b1;
              tmr_val   = LD_UNLOCK;
            end else begin
              state_nxt = IDLE;
              fail_nxt  = 1'b1;
            end
          end
        end
        UNLOCK: begin
          if (tmr_done) begin
            state_nxt = IDLE;
          end else begin
            unl_nxt = 1'b1;
          end
        end
        LOCKED: begin
          lock_nxt = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          pw_nxt    = '0;
          cnt_nxt   = '0;
        end
      endcase
    end

    busy_nxt = (state_nxt == SUBMIT) || (state_nxt == WAIT) ||
               (state_nxt == UNLOCK) || (state_nxt == LOCKED);
  end

  assign bus.pass_word  = pw_q;
  assign bus.digit_cnt  = cnt_q;
  assign bus.enter      = enter_q;
  assign bus.busy       = busy_q;
  assign bus.unlocked   = unl_q;
  assign bus.locked_out = lock_q;
  assign bus.bad_entry  = bad_q;
  assign bus.fail       = fail_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with a pass_word scoreboard.
module tb_keypad_entry_ctrl;

  localparam int DIGITS        = 3;
  localparam int ENTER_W       = 2;
  localparam int RESP_WAIT     = 2;
  localparam int TIMEOUT       = 1000;
  localparam int UNLOCK_CYCLES = 500;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_ctrl_if #(.DIGITS(DIGITS)) bus ();

  keypad_entry_ctrl #(
    .DIGITS        (DIGITS),
    .ENTER_W       (ENTER_W),
    .RESP_WAIT     (RESP_WAIT),
    .TIMEOUT       (TIMEOUT),
    .UNLOCK_CYCLES (UNLOCK_CYCLES)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [11:0] sb[$];
  logic [11:0] mdl_pw;
  int          mdl_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    bus.key_code  = d;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    if (mdl_cnt < DIGITS) begin
      mdl_pw  = {mdl_pw[7:0], d};
      mdl_cnt = mdl_cnt + 1;
    end
    chk("digit_cnt_after_key", 32'(bus.digit_cnt), 32'(mdl_cnt));
  endtask

  task automatic submit();
    if (mdl_cnt == DIGITS) sb.push_back(mdl_pw);
    bus.key_submit = 1'b1;
    tick();
    bus.key_submit = 1'b0;
    mdl_pw  = '0;
    mdl_cnt = 0;
  endtask

  // Called right after submit(); consumes one scoreboard entry on the first enter cycle.
  task automatic observe_enter(output int n);
    logic [11:0] e;
    n = 0;
    if (bus.enter === 1'b1) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pass_word_at_enter", 32'(bus.pass_word), 32'(e));
      end else begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end
    end
    while (bus.enter === 1'b1 && n < 16) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_fail();
    for (int i = 0; i < 10 && bus.fail !== 1'b1; i++) tick();
    chk("fail_pulse", 32'(bus.fail), 32'd1);
    tick();
    chk("fail_width", 32'(bus.fail), 32'd0);
    chk("idle_after_fail", 32'(bus.busy), 32'd0);
    chk("cnt_after_fail", 32'(bus.digit_cnt), 32'd0);
  endtask

  initial begin
    int          n;
    logic [11:0] e;

    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;
    bus.key_clear  = 1'b0;
    bus.key_submit = 1'b0;
    bus.access     = 1'b0;
    bus.alarm      = 1'b0;
    mdl_pw  = '0;
    mdl_cnt = 0;

    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_pass_word", 32'(bus.pass_word), 32'd0);
    chk("rst_digit_cnt", 32'(bus.digit_cnt), 32'd0);
    chk("rst_enter", 32'(bus.enter), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_unlocked", 32'(bus.unlocked), 32'd0);
    chk("rst_locked_out", 32'(bus.locked_out), 32'd0);
    chk("rst_bad_entry", 32'(bus.bad_entry), 32'd0);
    chk("rst_fail", 32'(bus.fail), 32'd0);
    rstn = 1'b1;
    tick();

    // Granted access with F,2,A
    press(4'hF);
    press(4'h2);
    press(4'hA);
    chk("pass_word_f2a", 32'(bus.pass_word), 32'h0F2A);
    bus.access = 1'b1;
    submit();
    chk("busy_in_submit", 32'(bus.busy), 32'd1);
    observe_enter(n);
    chk("enter_width", 32'(n), 32'(ENTER_W));
    for (int i = 0; i < 10 && bus.unlocked !== 1'b1; i++) tick();
    chk("unlocked_rise", 32'(bus.unlocked), 32'd1);
    bus.access = 1'b0;
    n = 0;
    while (bus.unlocked === 1'b1 && n < 600) begin
      n++;
      tick();
    end
    chk("unlock_len", 32'(n), 32'(UNLOCK_CYCLES));
    chk("idle_after_unlock", 32'(bus.busy), 32'd0);
    chk("cnt_after_unlock", 32'(bus.digit_cnt), 32'd0);

    // Short entry
    press(4'h0);
    press(4'hA);
    submit();
    chk("bad_entry_pulse", 32'(bus.bad_entry), 32'd1);
    chk("no_enter_short", 32'(bus.enter), 32'd0);
    chk("cnt_after_bad", 32'(bus.digit_cnt), 32'd0);
    tick();
    chk("bad_entry_width", 32'(bus.bad_entry), 32'd0);
    chk("no_enter_short_2", 32'(bus.enter), 32'd0);

    // Fourth key ignored, then rejected by the checker
    press(4'h9);
    press(4'h9);
    press(4'h9);
    press(4'h1);
    chk("pass_word_999", 32'(bus.pass_word), 32'h0999);
    submit();
    observe_enter(n);
    chk("enter_width_999", 32'(n), 32'(ENTER_W));
    wait_fail();
    chk("buffer_cleared_after_fail", 32'(bus.pass_word), 32'd0);

    // Idle timeout
    press(4'hE);
    press(4'hC);
    repeat (TIMEOUT - 1) tick();
    chk("cnt_before_timeout", 32'(bus.digit_cnt), 32'd2);
    tick();
    mdl_pw  = '0;
    mdl_cnt = 0;
    chk("cnt_at_timeout", 32'(bus.digit_cnt), 32'd0);
    chk("pw_at_timeout", 32'(bus.pass_word), 32'd0);
    chk("idle_at_timeout", 32'(bus.busy), 32'd0);

    // Clear beats a simultaneous key
    press(4'h5);
    bus.key_code  = 4'h7;
    bus.key_valid = 1'b1;
    bus.key_clear = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_clear = 1'b0;
    mdl_pw  = '0;
    mdl_cnt = 0;
    chk("clear_wins_cnt", 32'(bus.digit_cnt), 32'd0);
    chk("clear_wins_pw", 32'(bus.pass_word), 32'd0);

    // Second wrong attempt, third attempt raises alarm
    press(4'h1);
    press(4'h1);
    press(4'h1);
    submit();
    observe_enter(n);
    wait_fail();
    press(4'h2);
    press(4'h2);
    press(4'h2);
    submit();
    observe_enter(n);
    bus.alarm = 1'b1;
    for (int i = 0; i < 10 && bus.locked_out !== 1'b1; i++) tick();
    chk("locked_out_set", 32'(bus.locked_out), 32'd1);
    bus.alarm = 1'b0;
    bus.key_code  = 4'h3;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid  = 1'b0;
    bus.key_submit = 1'b1;
    tick();
    bus.key_submit = 1'b0;
    repeat (3) tick();
    chk("locked_persists", 32'(bus.locked_out), 32'd1);
    chk("locked_busy", 32'(bus.busy), 32'd1);
    chk("locked_keys_ignored", 32'(bus.digit_cnt), 32'd0);
    chk("locked_no_enter", 32'(bus.enter), 32'd0);
    rstn = 1'b0;
    #1;
    chk("lock_cleared_by_rst", 32'(bus.locked_out), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Reset during the enter strobe
    press(4'h4);
    press(4'h5);
    press(4'h6);
    submit();
    chk("enter_before_rst", 32'(bus.enter), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pass_word_456", 32'(bus.pass_word), 32'(e));
    end else begin
      chk("sb_underflow_456", 32'(sb.size()), 32'd1);
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("enter_async_drop", 32'(bus.enter), 32'd0);
    chk("pw_async_clear", 32'(bus.pass_word), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Front end of the locker. Collects hex key digits from the keypad into a password word and drives it, with an enter strobe, into the password checker.
- Samples the checker's access/alarm verdict.
- Holds an unlock window on success and latches a lockout on alarm.
- Sits between the keypad scanner and the per-user password-check path.

Parameters:
DIGITS, 3, number of hex digits per password; password width is 4*DIGITS.
ENTER_W, 2, cycles the enter strobe is held high.
RESP_WAIT, 2, cycles after enter falls before access/alarm are sampled.
TIMEOUT, 1000, idle cycles between digits before a partial entry is discarded.
UNLOCK_CYCLES, 500, cycles unlocked stays high after a granted access.

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe: key_code holds a new digit
key_code  in  4  hex digit value
key_clear  in  1  one-cycle strobe: discard partial entry
key_submit  in  1  one-cycle strobe: submit entry
access  in  1  checker verdict: password matched
alarm  in  1  checker verdict: attempt limit reached
pass_word  out  4*DIGITS  assembled password presented to the checker
enter  out  1  submit strobe to the checker
digit_cnt  out  clog2(DIGITS+1)  digits currently held
busy  out  1  high in SUBMIT/WAIT/UNLOCK/LOCKED; keys ignored
unlocked  out  1  door-release window active
locked_out  out  1  lockout latched
bad_entry  out  1  one-cycle pulse: submit with too few digits
fail  out  1  one-cycle pulse: checker rejected password

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE.
  - pass_word, digit_cnt, timers all 0.
  - enter, busy, unlocked, locked_out, bad_entry, fail all 0.
- States: IDLE, COLLECT, SUBMIT, WAIT, UNLOCK, LOCKED.
- IDLE/COLLECT key handling, one action per cycle, priority key_clear > key_submit > key_valid:
  - key_clear: pass_word=0, digit_cnt=0, go to IDLE.
  - key_submit with digit_cnt==DIGITS: go to SUBMIT. pass_word frozen.
  - key_submit with digit_cnt<DIGITS: bad_entry pulses 1 cycle, buffer cleared, go to IDLE. enter is not asserted.
  - key_valid with digit_cnt<DIGITS: pass_word <= {pass_word[4*DIGITS-5:0], key_code}; digit_cnt+1; idle timer cleared; state COLLECT. First key entered lands in the MS nibble once full, so F,2,A gives 12'hF2A.
  - key_valid with digit_cnt==DIGITS: ignored, no state change.
- Timeout: in COLLECT the idle timer counts every cycle with no accepted key. When it reaches TIMEOUT-1, the buffer is cleared and state goes to IDLE.
- SUBMIT:
  - enter=1 for exactly ENTER_W cycles, first high cycle is the cycle after submit was accepted.
  - Then go to WAIT with enter=0.
- WAIT:
  - Count RESP_WAIT cycles, then sample access/alarm in one cycle.
  - alarm=1: go to LOCKED.
  - else access=1: go to UNLOCK.
  - else fail pulses 1 cycle, go to IDLE.
  - Buffer is cleared on leaving WAIT in every case.
- UNLOCK: unlocked=1 for UNLOCK_CYCLES cycles, then IDLE. Keys ignored.
- LOCKED: locked_out=1 and busy=1. Exit only via rstn.
- alarm=1 observed in any state other than LOCKED forces LOCKED on the next edge, overriding all key actions. Buffer is cleared.
- busy is a registered decode of state. pass_word is stable from SUBMIT entry through the WAIT sample cycle.
- All strobes (enter, bad_entry, fail) are registered; no combinational input-to-output paths.
- Reset mid-SUBMIT drops enter immediately (asynchronous).

Decomposition:
- Shared package holds:
  - state enum: IDLE, COLLECT, SUBMIT, WAIT, UNLOCK, LOCKED.
  - DIGIT_W=4.
  - helper function for clog2 widths.
- One sub-module is natural: down_timer, a loadable down-counter with done flag. It is reused for the idle timeout, enter width, response wait and unlock window.
- The main FSM and shift buffer stay in keypad_entry_ctrl.

Test Plan:
1. Keys F,2,A then submit, checker returns access=1 -> pass_word=12'hF2A during enter; enter high 2 cycles; unlocked high 500 cycles; then IDLE with digit_cnt=0.
2. Keys 0,A then submit -> bad_entry 1-cycle pulse; enter never asserted; digit_cnt=0.
3. Keys 9,9,9, fourth key 1, then submit -> fourth key ignored; pass_word=12'h999 during enter.
4. Keys E,C then 1000 idle cycles -> buffer cleared at cycle 1000; digit_cnt=0; state IDLE.
5. Wrong password, access=0/alarm=0 -> fail pulse. Third attempt returns alarm=1 -> locked_out=1 persists; keys ignored until rstn low.
6. key_clear and key_valid in the same cycle -> clear wins, digit_cnt=0. rstn low during enter -> enter=0 asynchronously.
